// File: rtl/cache_defs.sv
// Shared definitions for the data-cache to memory line link: request/response
// structs, the memory responder FSM states and line geometry constants.
package cache_defs;

  localparam int CACHE_LINE_WIDTH = 128;
  localparam int LINE_OFFSET_BITS = $clog2(CACHE_LINE_WIDTH / 8);

  typedef struct packed {
    logic                        req;
    logic                        w_en;
    logic [31:0]                 addr;
    logic [CACHE_LINE_WIDTH-1:0] w_data;
  } type_dcache2mem_s;

  typedef struct packed {
    logic                        ack;
    logic [CACHE_LINE_WIDTH-1:0] r_data;
  } type_mem2dcache_s;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_BUSY,
    DMEM_ACK
  } type_dmem_resp_states_e;

  // Counter width able to hold (max latency - 2); never narrower than one bit.
  function automatic int latency_cnt_width(input int max_latency);
    return (max_latency > 2) ? $clog2(max_latency) : 1;
  endfunction

endpackage

// File: rtl/dmem_line_ram.sv
// Single-port line store: synchronous write, registered read with enable.
// The read register only updates on enabled reads, so writes leave it unchanged.
module dmem_line_ram #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: neither the array nor its read register has a reset; a reset here
  // would stop the tools from mapping this onto block RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/wb_dcache_mem_responder.sv
// Slave end of the dcache-to-memory line link: accepts line reads/writes,
// waits a programmable latency, then commits/loads the line and acks for one cycle.
module wb_dcache_mem_responder
  import cache_defs::*;
#(
  parameter int LINE_WIDTH  = CACHE_LINE_WIDTH,
  parameter int DEPTH_LINES = 1024,
  parameter int RD_LATENCY  = 4,
  parameter int WR_LATENCY  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_sel_i,
  input  type_dcache2mem_s dcache2mem_i,
  input  logic             dcache2mem_kill_i,
  output type_mem2dcache_s mem2dcache_o,
  output logic             busy_o
);

  localparam int IDX_W   = $clog2(DEPTH_LINES);
  localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CNT_W   = latency_cnt_width(MAX_LAT);

  localparam logic [CNT_W-1:0] RD_CNT_INIT =
    (RD_LATENCY >= 2) ? CNT_W'(RD_LATENCY - 2) : '0;
  localparam logic [CNT_W-1:0] WR_CNT_INIT =
    (WR_LATENCY >= 2) ? CNT_W'(WR_LATENCY - 2) : '0;

  type_dmem_resp_states_e state;
  logic [CNT_W-1:0]       cnt;
  logic                   ack_q;
  logic                   rd_valid;

  logic                   lat_w_en;
  logic [IDX_W-1:0]       lat_idx;
  logic [LINE_WIDTH-1:0]  lat_wdata;

  logic                   accept;
  logic                   req_short;
  logic                   busy_done;
  logic                   enter_ack;
  logic [IDX_W-1:0]       req_idx;
  logic                   ram_we;
  logic [IDX_W-1:0]       ram_idx;
  logic [LINE_WIDTH-1:0]  ram_wdata;
  logic [LINE_WIDTH-1:0]  ram_rdata;
  logic                   unused_addr;

  // Offset bits below the line and bits above the store size are don't-care.
  assign req_idx     = dcache2mem_i.addr[LINE_OFFSET_BITS +: IDX_W];
  assign unused_addr = ^dcache2mem_i.addr;

  // NOTE: every signal gets a default at the top of the block so no path
  // through it leaves a value unassigned and infers a latch.
  always_comb begin
    accept    = 1'b0;
    req_short = 1'b0;
    busy_done = 1'b0;
    if (state == DMEM_IDLE) begin
      accept    = dcache2mem_i.req && mem_sel_i && !dcache2mem_kill_i;
      req_short = dcache2mem_i.w_en ? (WR_LATENCY == 1) : (RD_LATENCY == 1);
    end
    if (state == DMEM_BUSY) begin
      busy_done = !dcache2mem_kill_i && (cnt == '0);
    end
    enter_ack = !rst && ((accept && req_short) || busy_done);
  end

  // Single-cycle latency must reach the array straight from the request;
  // otherwise the latched copy drives it.
  always_comb begin
    ram_we    = lat_w_en;
    ram_idx   = lat_idx;
    ram_wdata = lat_wdata;
    if (state == DMEM_IDLE) begin
      ram_we    = dcache2mem_i.w_en;
      ram_idx   = req_idx;
      ram_wdata = dcache2mem_i.w_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DMEM_IDLE;
      cnt      <= '0;
      ack_q    <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      ack_q <= enter_ack;
      case (state)
        DMEM_IDLE: begin
          if (accept) begin
            if (req_short) begin
              state <= DMEM_ACK;
            end else begin
              state <= DMEM_BUSY;
              cnt   <= dcache2mem_i.w_en ? WR_CNT_INIT : RD_CNT_INIT;
            end
          end
        end
        DMEM_BUSY: begin
          if (dcache2mem_kill_i) begin
            state <= DMEM_IDLE;
          end else if (cnt == '0) begin
            state <= DMEM_ACK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DMEM_ACK: state <= DMEM_IDLE;
        default:  state <= DMEM_IDLE;
      endcase
      if (enter_ack && !ram_we) begin
        rd_valid <= 1'b1;
      end
    end
  end

  // Request latches are pure datapath, only meaningful while a transaction is live.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_w_en  <= dcache2mem_i.w_en;
      lat_idx   <= req_idx;
      lat_wdata <= dcache2mem_i.w_data;
    end
  end

  dmem_line_ram #(
    .WIDTH(LINE_WIDTH),
    .DEPTH(DEPTH_LINES)
  ) u_ram (
    .clk  (clk),
    .en   (enter_ack),
    .we   (ram_we),
    .addr (ram_idx),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  // The array's read register is not reset, so read data reads as zero until
  // the first completed read after reset.
  assign mem2dcache_o.ack    = ack_q;
  assign mem2dcache_o.r_data = rd_valid ? ram_rdata : '0;
  assign busy_o              = (state != DMEM_IDLE);

endmodule

// File: doc/wb_dcache_mem_responder.md
# wb_dcache_mem_responder

Memory-side responder for the write-back data cache line interface. Accepts line-wide read (refill) and write (write-back) requests issued by the data cache on `type_dcache2mem_s` and answers on `type_mem2dcache_s` with a one-cycle ack after a programmable latency. It backs a line-organised data memory and honours the cache's kill signal. It sits in the memory subsystem as the slave end of the dcache-to-memory link and serves as both the SoC data memory and the verification memory model.

## Interface
Parameters:
- `LINE_WIDTH`, 128, cache line width in bits; must match the `cache_defs` line width.
- `DEPTH_LINES`, 1024, number of lines in the backing store; power of two.
- `RD_LATENCY`, 4, cycles from request accept to ack for reads; ≥1.
- `WR_LATENCY`, 4, cycles from request accept to ack for writes; ≥1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `mem_sel_i`  in  1  region select; a request is accepted only while high.
- `dcache2mem_i`  in  `type_dcache2mem_s`  request fields `req`, `w_en`, `addr` (32 b), `w_data` (`LINE_WIDTH`).
- `dcache2mem_kill_i`  in  1  abort the in-flight transaction.
- `mem2dcache_o`  out  `type_mem2dcache_s`  response fields `ack`, `r_data` (`LINE_WIDTH`).
- `busy_o`  out  1  high in every state other than IDLE.

## Operation
- The FSM has three states: IDLE, BUSY and ACK.
- IDLE:
  - A request is accepted when `req && mem_sel_i && !dcache2mem_kill_i`.
  - On accept, latch `w_en`, the line index and `w_data`, and set L to `WR_LATENCY` if `w_en` else `RD_LATENCY`.
  - If L==1, go to ACK. Otherwise go to BUSY with `cnt = L-2`.
- BUSY:
  - If kill is high, go to IDLE. No array write, no ack.
  - Else if `cnt==0`, go to ACK.
  - Else decrement `cnt`.
- Entering ACK, on the same edge:
  - A write stores the latched `w_data` at the latched index.
  - A read loads the line at the index into the `r_data` register.
- ACK: `ack` is high for exactly this cycle, then the FSM returns to IDLE unconditionally. Kill seen in ACK is ignored because the write has already committed.
- Line index is `addr[$clog2(LINE_WIDTH/8) +: $clog2(DEPTH_LINES)]`. Lower offset bits and upper bits are ignored, so out-of-range addresses wrap modulo `DEPTH_LINES`.
- `r_data` holds its value until the next completed read. Writes and kills leave it unchanged.
- Request fields are sampled only at accept. Changes to `addr` or `w_data` during BUSY have no effect.

## Timing
- Request first high in cycle 0 (accepted): `ack` is high in cycle L and low in every other cycle.
- `req` must be low in the cycle after `ack`. A `req` high in IDLE is always a new transaction, so the earliest back-to-back accept is the cycle after ack.
- Reset values: state IDLE, `cnt`=0, `ack`=0, `r_data`=0, `busy_o`=0. Array contents are not reset.
- Reset mid-transaction returns to IDLE on the next edge. No ack is issued and no write is performed if reset is asserted on the ACK-entry edge.
- Simultaneous `req` and kill in IDLE: not accepted. Kill in the final BUSY cycle (`cnt==0`): abort wins, no write.
- `req` high with `mem_sel_i` low: ignored; the FSM stays in IDLE.

## Structure
- Shared package `cache_defs`:
  - `type_dcache2mem_s` and `type_mem2dcache_s` (reused).
  - The FSM state enum `type_dmem_resp_states_e`.
  - The line-offset constant derived from the line width.
- One sub-module, `dmem_line_ram`:
  - Single-port, `DEPTH_LINES` × `LINE_WIDTH`.
  - Synchronous write and registered read with enable.
  - No reset, so it infers BRAM.
- The FSM, latency counter (`$clog2(max latency)` bits) and request latches live in the top module.

## Test plan
- Read latency: preload line 3 = `128'hA5A5…`, L=4; `req`, `w_en`=0, `addr`=`0x30` in cycle 0 → `ack` high only in cycle 4, `r_data`=`A5A5…`, `busy_o` high in cycles 1–3.
- Write then read: write `w_data`=`128'h1234…` to `0x40` → ack in cycle 4 (`WR_LATENCY`=4). Read `0x40` → returns `1234…`. Reads of other lines are unchanged.
- Kill: issue a write to `0x50` and assert kill in cycle 2 → no ack, FSM back in IDLE in cycle 3. A following read of `0x50` returns the old contents.
- Kill in ACK cycle and kill with req in IDLE: the ACK-cycle kill still acks and commits the write. The IDLE kill+req is not accepted (`busy_o` stays 0).
- L=1 and wrap: set `RD_LATENCY`=1 and read `addr` = `DEPTH_LINES*16 + 0x20` → ack in cycle 1 with line 2 data.
- Reset mid-BUSY: assert `rst` in cycle 2 of a write → `ack`=0, `r_data`=0, `busy_o`=0 next cycle, and the target line is not written.
